// File: rtl/pong_pkg.sv
// Shared types for the pong score keeper: FSM states, winner codes, score width
// and the saturating score increment.
package pong_pkg;

   localparam int SCORE_W = 4;

   typedef logic [SCORE_W-1:0] score_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SERVE,
      ST_PLAY,
      ST_POINT,
      ST_OVER
   } state_t;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;

   // A score never passes the winning value, even if an award slips through.
   function automatic score_t sat_inc(input score_t s, input score_t lim);
      return (s < lim) ? score_t'(s + score_t'(1)) : s;
   endfunction

endpackage

// File: rtl/btn_sync_fall.sv
// Two-flop synchronizer for an asynchronous active-low button, followed by a
// falling-edge detector producing a single-cycle strobe.
module btn_sync_fall (
   input  logic pixel_clk,
   input  logic reset_n,
   input  logic in_n,
   output logic fall
);

   logic sync1_reg;
   logic sync2_reg;
   logic prev_reg;

   // All stages reset to the released level so no edge appears after reset.
   always_ff @(posedge pixel_clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_reg <= 1'b1;
         sync2_reg <= 1'b1;
         prev_reg  <= 1'b1;
      end else begin
         sync1_reg <= in_n;
         sync2_reg <= sync1_reg;
         prev_reg  <= sync2_reg;
      end
   end

   assign fall = prev_reg & ~sync2_reg;

endmodule

// File: rtl/pong_score_keeper.sv
// Pong score keeper: serve countdown, wall-hit scoring, game-over detection.
// Every output is a flop; ball_hold/point_pulse/game_over follow the next state.
module pong_score_keeper
   import pong_pkg::*;
#(
   parameter int WIN_SCORE   = 9,
   parameter int SERVE_TICKS = 40
) (
   input  logic         pixel_clk,
   input  logic         reset_n,
   input  logic         tick_en,
   input  logic         serve_n,
   input  logic [3:0]   ball_edge,
   output logic [3:0]   score_one,
   output logic [3:0]   score_two,
   output logic         ball_hold,
   output logic         serve_dir,
   output logic         point_pulse,
   output logic         game_over,
   output logic [1:0]   winner
);

   localparam score_t     WIN_VAL   = score_t'(WIN_SCORE);
   localparam logic [7:0] TICKS_VAL = 8'(SERVE_TICKS);

   logic       serve_evt;
   state_t     state_reg, state_next;
   logic [7:0] cnt_reg, cnt_next;
   score_t     score_one_reg, score_one_next;
   score_t     score_two_reg, score_two_next;
   logic       p1_scored_reg, p1_scored_next;
   logic       serve_dir_reg, serve_dir_next;
   logic [1:0] winner_reg, winner_next;
   logic       point_pulse_reg;
   logic       game_over_reg;
   logic       ball_hold_reg;
   logic       hit_left;
   logic       hit_right;
   logic       unused_edges;

   btn_sync_fall u_sync (
      .pixel_clk (pixel_clk),
      .reset_n   (reset_n),
      .in_n      (serve_n),
      .fall      (serve_evt)
   );

   // Flags are active-low; both walls low at once is a glitch and ignored.
   assign hit_left     = ~ball_edge[3] &  ball_edge[1];
   assign hit_right    =  ball_edge[3] & ~ball_edge[1];
   assign unused_edges = ball_edge[2] ^ ball_edge[0];

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      score_one_next = score_one_reg;
      score_two_next = score_two_reg;
      p1_scored_next = p1_scored_reg;
      serve_dir_next = serve_dir_reg;
      winner_next    = winner_reg;
      case (state_reg)
         ST_IDLE: begin
            if (serve_evt) begin
               state_next = ST_SERVE;
               cnt_next   = TICKS_VAL;
            end
         end
         ST_SERVE: begin
            if (tick_en) begin
               if (cnt_reg <= 8'd1) begin
                  state_next = ST_PLAY;
                  cnt_next   = 8'd0;
               end else begin
                  cnt_next = cnt_reg - 8'd1;
               end
            end
         end
         ST_PLAY: begin
            if (tick_en && hit_right) begin
               state_next     = ST_POINT;
               p1_scored_next = 1'b1;
               score_one_next = sat_inc(score_one_reg, WIN_VAL);
               serve_dir_next = 1'b1;
            end else if (tick_en && hit_left) begin
               state_next     = ST_POINT;
               p1_scored_next = 1'b0;
               score_two_next = sat_inc(score_two_reg, WIN_VAL);
               serve_dir_next = 1'b0;
            end
         end
         ST_POINT: begin
            // The score was already bumped on entry, so compare it directly.
            if ((p1_scored_reg ? score_one_reg : score_two_reg) == WIN_VAL) begin
               state_next  = ST_OVER;
               winner_next = p1_scored_reg ? WIN_P1 : WIN_P2;
            end else begin
               state_next = ST_SERVE;
               cnt_next   = TICKS_VAL;
            end
         end
         ST_OVER: begin
            if (serve_evt) begin
               state_next     = ST_SERVE;
               cnt_next       = TICKS_VAL;
               score_one_next = '0;
               score_two_next = '0;
               winner_next    = WIN_NONE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge pixel_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg       <= ST_IDLE;
         cnt_reg         <= 8'd0;
         score_one_reg   <= '0;
         score_two_reg   <= '0;
         p1_scored_reg   <= 1'b0;
         serve_dir_reg   <= 1'b1;
         winner_reg      <= WIN_NONE;
         point_pulse_reg <= 1'b0;
         game_over_reg   <= 1'b0;
         ball_hold_reg   <= 1'b1;
      end else begin
         state_reg       <= state_next;
         cnt_reg         <= cnt_next;
         score_one_reg   <= score_one_next;
         score_two_reg   <= score_two_next;
         p1_scored_reg   <= p1_scored_next;
         serve_dir_reg   <= serve_dir_next;
         winner_reg      <= winner_next;
         point_pulse_reg <= (state_next == ST_POINT);
         game_over_reg   <= (state_next == ST_OVER);
         ball_hold_reg   <= (state_next != ST_PLAY);
      end
   end

   assign score_one   = score_one_reg;
   assign score_two   = score_two_reg;
   assign ball_hold   = ball_hold_reg;
   assign serve_dir   = serve_dir_reg;
   assign point_pulse = point_pulse_reg;
   assign game_over   = game_over_reg;
   assign winner      = winner_reg;

endmodule

// File: tb/tb_pong_score_keeper.sv
// Directed bench for pong_score_keeper: serve countdown, scoring, glitch
// rejection, mid-play reset and a full game to WIN_SCORE=3.
module tb_pong_score_keeper;
   import pong_pkg::*;

   logic       pixel_clk = 1'b0;
   logic       reset_n   = 1'b1;
   logic       tick_en   = 1'b0;
   logic       serve_n   = 1'b1;
   logic [3:0] ball_edge = 4'hF;
   logic [3:0] score_one;
   logic [3:0] score_two;
   logic       ball_hold;
   logic       serve_dir;
   logic       point_pulse;
   logic       game_over;
   logic [1:0] winner;

   int n_checks  = 0;
   int n_fail    = 0;
   int pulse_cnt = 0;
   int fall_cnt  = 0;
   int p0;

   pong_score_keeper #(
      .WIN_SCORE   (3),
      .SERVE_TICKS (40)
   ) dut (
      .pixel_clk   (pixel_clk),
      .reset_n     (reset_n),
      .tick_en     (tick_en),
      .serve_n     (serve_n),
      .ball_edge   (ball_edge),
      .score_one   (score_one),
      .score_two   (score_two),
      .ball_hold   (ball_hold),
      .serve_dir   (serve_dir),
      .point_pulse (point_pulse),
      .game_over   (game_over),
      .winner      (winner)
   );

   always #5 pixel_clk = ~pixel_clk;

   always @(posedge pixel_clk) begin
      if (point_pulse)     pulse_cnt <= pulse_cnt + 1;
      if (dut.u_sync.fall) fall_cnt  <= fall_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
      $display("check %-14s observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic do_tick();
      @(negedge pixel_clk);
      tick_en = 1'b1;
      @(negedge pixel_clk);
      tick_en = 1'b0;
   endtask

   task automatic run_ticks(input int n);
      repeat (n) do_tick();
   endtask

   task automatic press_serve();
      @(negedge pixel_clk);
      serve_n = 1'b0;
      repeat (3) @(negedge pixel_clk);
      serve_n = 1'b1;
      repeat (4) @(negedge pixel_clk);
   endtask

   initial begin
      // reset state
      #2 reset_n = 1'b0;
      repeat (2) @(negedge pixel_clk);
      check("rst_score1", 8'(score_one), 8'd0);
      check("rst_score2", 8'(score_two), 8'd0);
      check("rst_hold", 8'(ball_hold), 8'd1);
      check("rst_dir", 8'(serve_dir), 8'd1);
      check("rst_winner", 8'(winner), 8'd0);
      check("rst_over", 8'(game_over), 8'd0);
      check("rst_pulse", 8'(point_pulse), 8'd0);
      check("rst_state", 8'(dut.state_reg), 8'(ST_IDLE));
      reset_n = 1'b1;
      repeat (3) @(negedge pixel_clk);
      check("no_spur_serve", 8'(fall_cnt), 8'd0);
      check("idle_state", 8'(dut.state_reg), 8'(ST_IDLE));

      // serve and countdown of exactly 40 ticks
      press_serve();
      check("one_serve_evt", 8'(fall_cnt), 8'd1);
      check("serve_state", 8'(dut.state_reg), 8'(ST_SERVE));
      run_ticks(39);
      check("hold_tick39", 8'(ball_hold), 8'd1);
      do_tick();
      check("hold_tick40", 8'(ball_hold), 8'd0);
      check("play_state", 8'(dut.state_reg), 8'(ST_PLAY));

      // left wall hit: player 2 scores
      ball_edge = 4'b0111;
      check("pulse_before", 8'(point_pulse), 8'd0);
      do_tick();
      check("pulse_p2", 8'(point_pulse), 8'd1);
      check("p2_score2", 8'(score_two), 8'd1);
      check("p2_score1", 8'(score_one), 8'd0);
      check("p2_dir", 8'(serve_dir), 8'd0);
      check("p2_hold", 8'(ball_hold), 8'd1);
      ball_edge = 4'hF;
      @(negedge pixel_clk);
      check("pulse_after", 8'(point_pulse), 8'd0);
      check("p2_reserve", 8'(dut.state_reg), 8'(ST_SERVE));

      // right wall held for 5 ticks: exactly one point for player 1
      run_ticks(40);
      check("play2_hold", 8'(ball_hold), 8'd0);
      ball_edge = 4'b1101;
      p0 = pulse_cnt;
      run_ticks(5);
      ball_edge = 4'hF;
      @(negedge pixel_clk);
      check("held_one_pt", 8'(pulse_cnt - p0), 8'd1);
      check("held_score1", 8'(score_one), 8'd1);
      check("held_score2", 8'(score_two), 8'd1);
      check("held_dir", 8'(serve_dir), 8'd1);
      check("held_state", 8'(dut.state_reg), 8'(ST_SERVE));
      run_ticks(36);
      check("play3_state", 8'(dut.state_reg), 8'(ST_PLAY));

      // both walls low: ignored
      ball_edge = 4'b0101;
      p0 = pulse_cnt;
      run_ticks(3);
      check("both_no_pt", 8'(pulse_cnt - p0), 8'd0);
      check("both_score1", 8'(score_one), 8'd1);
      check("both_score2", 8'(score_two), 8'd1);
      check("both_hold", 8'(ball_hold), 8'd0);

      // asynchronous reset in PLAY while a right-wall hit is presented
      ball_edge = 4'b1101;
      @(negedge pixel_clk);
      tick_en = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      check("mid_score1", 8'(score_one), 8'd0);
      check("mid_score2", 8'(score_two), 8'd0);
      check("mid_hold", 8'(ball_hold), 8'd1);
      check("mid_pulse", 8'(point_pulse), 8'd0);
      check("mid_dir", 8'(serve_dir), 8'd1);
      @(negedge pixel_clk);
      tick_en = 1'b0;
      reset_n = 1'b1;
      p0 = pulse_cnt;
      run_ticks(4);
      check("post_no_pt", 8'(pulse_cnt - p0), 8'd0);
      check("post_score1", 8'(score_one), 8'd0);
      check("post_state", 8'(dut.state_reg), 8'(ST_IDLE));
      check("post_no_serve", 8'(fall_cnt), 8'd1);
      ball_edge = 4'hF;

      // full game: player 1 reaches WIN_SCORE=3
      press_serve();
      for (int k = 1; k <= 3; k++) begin
         run_ticks(40);
         ball_edge = 4'b1101;
         do_tick();
         check("game_score1", 8'(score_one), 8'(k));
         check("game_pulse", 8'(point_pulse), 8'd1);
         ball_edge = 4'hF;
         @(negedge pixel_clk);
         if (k < 3) check("game_not_over", 8'(game_over), 8'd0);
      end
      check("over_flag", 8'(game_over), 8'd1);
      check("over_winner", 8'(winner), 8'(WIN_P1));
      check("over_score1", 8'(score_one), 8'd3);
      check("over_score2", 8'(score_two), 8'd0);
      check("over_hold", 8'(ball_hold), 8'd1);
      check("over_state", 8'(dut.state_reg), 8'(ST_OVER));
      repeat (5) @(negedge pixel_clk);
      check("winner_held", 8'(winner), 8'(WIN_P1));

      // serve from OVER clears the game
      press_serve();
      check("new_score1", 8'(score_one), 8'd0);
      check("new_score2", 8'(score_two), 8'd0);
      check("new_winner", 8'(winner), 8'(WIN_NONE));
      check("new_over", 8'(game_over), 8'd0);
      check("new_state", 8'(dut.state_reg), 8'(ST_SERVE));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pong_score_keeper.md
PONG_SCORE_KEEPER -- requirements
Module: pong_score_keeper

Interface
REQ-001 The block SHALL have parameter WIN_SCORE, default 9, the points needed to win (legal 1..9, one hex digit).
REQ-002 The block SHALL have parameter SERVE_TICKS, default 40, the number of game ticks spent in SERVE before play resumes (legal 1..255).
REQ-003 The block SHALL have port pixel_clk, input, 1, the single system clock.
REQ-004 The block SHALL have port reset_n, input, 1, the reset: asynchronous, active-low.
REQ-005 The block SHALL have port tick_en, input, 1, a one-cycle game-step strobe synchronous to pixel_clk.
REQ-006 The block SHALL have port serve_n, input, 1, the raw active-low serve button (asynchronous).
REQ-007 The block SHALL have port ball_edge, input, 4, the ball edge flags, active-low: [1]=right wall, [3]=left wall, [0]/[2] ignored.
REQ-008 The block SHALL have port score_one / score_two, output, 4 each, the player 1 (left) and player 2 (right) scores in binary, 0..WIN_SCORE.
REQ-009 The block SHALL have port ball_hold, output, 1, high when the ball must be parked at its initial position with zero offset.
REQ-010 The block SHALL have port serve_dir, output, 1, the initial x direction for the next serve: 0=toward left, 1=toward right.
REQ-011 The block SHALL have port point_pulse, output, 1, a one-cycle strobe on every scored point.
REQ-012 The block SHALL have port game_over, output, 1, high in state OVER.
REQ-013 The block SHALL have port winner, output, 2, the winner: 00=none, 01=player 1, 10=player 2.

Function
REQ-014 serve_n SHALL pass through a 2-FF synchronizer; a serve event SHALL be the synchronized 1->0 transition, one pixel_clk wide.
REQ-015 The FSM SHALL have states IDLE, SERVE, PLAY, POINT, OVER.
REQ-016 IDLE: ball_hold=1; on a serve event the FSM SHALL go to SERVE and load the tick counter with SERVE_TICKS.
REQ-017 SERVE: ball_hold=1; the counter SHALL decrement only on cycles with tick_en=1.
REQ-018 SERVE SHALL go to PLAY on the tick_en cycle where the counter is 1, giving exactly SERVE_TICKS ticks in SERVE.
REQ-019 PLAY: ball_hold=0; ball_edge SHALL be sampled only on cycles with tick_en=1.
REQ-020 In PLAY, ball_edge[3]=0 with ball_edge[1]=1 SHALL award player 2; ball_edge[1]=0 with ball_edge[3]=1 SHALL award player 1; both low SHALL be ignored, staying in PLAY.
REQ-021 On an award the FSM SHALL go to POINT on the next clock.
REQ-022 POINT SHALL last exactly one cycle. In POINT:
- point_pulse=1 and ball_hold=1;
- the awarded score increments by 1;
- serve_dir is set toward the player who lost the point (player 1 scored -> 1, player 2 scored -> 0).
REQ-023 Leaving POINT, the FSM SHALL go to OVER if the incremented score equals WIN_SCORE; otherwise it SHALL go to SERVE, reloading the counter with SERVE_TICKS.
REQ-024 A score SHALL never exceed WIN_SCORE; an increment at WIN_SCORE is impossible by construction and SHALL be blocked by saturation logic.
REQ-025 OVER: ball_hold=1, game_over=1, winner set and held.
REQ-026 In OVER, a serve event SHALL clear both scores and winner, and the FSM SHALL go to SERVE.
REQ-027 Serve events in SERVE, PLAY or POINT SHALL be ignored.
REQ-028 All outputs SHALL be registered; point_pulse SHALL rise exactly one clock after the tick_en cycle that detected the wall hit.

Reset
REQ-029 On reset_n=0, asynchronously: state=IDLE, both scores=0, counter=0, serve_dir=1, winner=00, point_pulse=0, game_over=0, ball_hold=1, synchronizer flops=1 (released).
REQ-030 Reset asserted mid-SERVE, PLAY or POINT SHALL abort with no score change visible after release.
REQ-031 After reset release, no serve event SHALL be generated unless serve_n is low.

Structure
REQ-032 The state enum, the winner encodings and the 4-bit score width SHALL live in shared package pong_pkg.
REQ-033 The synchronizer plus falling-edge detector SHALL be sub-module btn_sync_fall (ports pixel_clk, reset_n, in_n, fall).

Verification
REQ-034 The bench SHALL cover: reset, then serve_n pulsed low 3 cycles -> one serve event; 40 tick_en strobes later ball_hold falls to 0 with state PLAY.
REQ-035 The bench SHALL cover: PLAY, ball_edge=4'b0111 on a tick -> point_pulse for 1 cycle one clock later; score_two=1; serve_dir=0; return to SERVE.
REQ-036 The bench SHALL cover: ball_edge=4'b1101 held for 5 ticks in PLAY -> only one point (second detection falls inside SERVE and is ignored).
REQ-037 The bench SHALL cover: ball_edge=4'b0101 in PLAY -> no point, scores unchanged.
REQ-038 The bench SHALL cover: WIN_SCORE=3, player 1 scores 3 times -> game_over=1, winner=01, score_one=3; a serve then gives scores 0/0, winner=00, state SERVE.
REQ-039 The bench SHALL cover: reset_n pulsed low during PLAY while ball_edge[1]=0 -> outputs at reset values, no point_pulse after release.
